// File: rtl/ethernet_rx.sv
// Ethernet/IPv4/UDP receive engine. It filters frames against the local addresses, looks up the sender's
// connection and delivers the realigned payload. Optional statistics counters: define ETH_RX_STATS_EN.
module ethernet_rx #(
    parameter int DATA_WIDTH    = 512,
    parameter int CONN_ID_WIDTH = 18,
    parameter int STAT_WIDTH    = 32
) (
    input  logic                      rx_axis_aclk,
    input  logic                      rx_axis_areset,
    input  logic                      rx_engine_enable,
    input  logic [47:0]               my_config_macAddr,
    input  logic [31:0]               my_config_ipAddr,
    input  logic [15:0]               my_config_udpPort,
    input  logic [DATA_WIDTH-1:0]     cmac_rx_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]   cmac_rx_axis_tkeep,
    input  logic                      cmac_rx_axis_tvalid,
    input  logic                      cmac_rx_axis_tlast,
    output logic                      cmac_rx_axis_tready,
    output logic [DATA_WIDTH-1:0]     udp_rx_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]   udp_rx_axis_tkeep,
    output logic                      udp_rx_axis_tvalid,
    output logic                      udp_rx_axis_tlast,
    output logic [CONN_ID_WIDTH-1:0]  udp_rx_axis_tuser,
    input  logic                      udp_rx_axis_tready,
    output logic                      m01_axis_fw_lookup_valid,
    output logic [47:0]               m01_axis_fw_lookup_macAddr,
    output logic [31:0]               m01_axis_fw_lookup_ipAddr,
    output logic [15:0]               m01_axis_fw_lookup_udpPort,
    input  logic                      m01_axis_fw_lookup_ready,
    input  logic                      s01_axis_fw_lookup_valid,
    input  logic                      s01_axis_fw_lookup_hit,
    input  logic [CONN_ID_WIDTH-1:0]  s01_axis_fw_lookup_connectionId,
    output logic                      s01_axis_fw_lookup_ready
`ifdef ETH_RX_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0]     stat_rx_ok,
    output logic [STAT_WIDTH-1:0]     stat_rx_filtered,
    output logic [STAT_WIDTH-1:0]     stat_rx_miss
`endif
);

    typedef enum logic [2:0] {IDLE, LOOKUP, STREAM, FLUSH, DRAIN, DROP} state_t;

    state_t state_reg, state_next;

    logic [175:0]             resid_reg;
    logic [15:0]              rem_reg;
    logic [4:0]               held_reg;
    logic                     last_seen_reg;
    logic                     drop_miss_reg;
    logic [CONN_ID_WIDTH-1:0] conn_id_reg;

    logic                     lookup_valid_reg;
    logic [47:0]              lookup_mac_reg;
    logic [31:0]              lookup_ip_reg;
    logic [15:0]              lookup_port_reg;

    logic [511:0]             out_data_reg;
    logic [63:0]              out_keep_reg;
    logic                     out_valid_reg;
    logic                     out_last_reg;
    logic [CONN_ID_WIDTH-1:0] out_user_reg;

    logic [47:0] dst_mac, src_mac;
    logic [31:0] src_ip, dst_ip;
    logic [15:0] etype, src_port, dst_port, udp_len;
    logic [7:0]  ver_ihl, proto;
    logic [13:0] mf_frag;
    logic [6:0]  in_cnt, flush_cnt;
    logic        accept, out_free, in_hs;

    logic         in_ready, emit, ev_ok, ev_filt, ev_miss;
    logic [511:0] beat_data;
    logic [63:0]  beat_keep;
    logic         beat_last;

    function automatic logic [6:0] keep_count(input logic [63:0] k);
        logic [6:0] c;
        c = '0;
        for (int i = 0; i < 64; i++) c = c + {6'd0, k[i]};
        return c;
    endfunction

    function automatic logic [63:0] keep_mask(input logic [6:0] n);
        return (n >= 7'd64) ? '1 : ((64'd1 << n) - 64'd1);
    endfunction

    // Header fields are big-endian on the wire, byte 0 in the low byte lane.
    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_mac
            assign dst_mac[47-8*gi -: 8] = cmac_rx_axis_tdata[8*gi +: 8];
            assign src_mac[47-8*gi -: 8] = cmac_rx_axis_tdata[8*(6+gi) +: 8];
        end
        for (genvar gi = 0; gi < 4; gi++) begin : g_ip
            assign src_ip[31-8*gi -: 8] = cmac_rx_axis_tdata[8*(26+gi) +: 8];
            assign dst_ip[31-8*gi -: 8] = cmac_rx_axis_tdata[8*(30+gi) +: 8];
        end
        for (genvar gi = 0; gi < 2; gi++) begin : g_16
            assign etype[15-8*gi -: 8]    = cmac_rx_axis_tdata[8*(12+gi) +: 8];
            assign src_port[15-8*gi -: 8] = cmac_rx_axis_tdata[8*(34+gi) +: 8];
            assign dst_port[15-8*gi -: 8] = cmac_rx_axis_tdata[8*(36+gi) +: 8];
            assign udp_len[15-8*gi -: 8]  = cmac_rx_axis_tdata[8*(38+gi) +: 8];
        end
    endgenerate

    assign ver_ihl   = cmac_rx_axis_tdata[8*14 +: 8];
    assign proto     = cmac_rx_axis_tdata[8*23 +: 8];
    assign mf_frag   = {cmac_rx_axis_tdata[8*20 +: 6], cmac_rx_axis_tdata[8*21 +: 8]};
    assign in_cnt    = keep_count(cmac_rx_axis_tkeep);
    assign flush_cnt = (rem_reg < {11'd0, held_reg}) ? rem_reg[6:0] : {2'b00, held_reg};
    assign out_free  = !out_valid_reg || udp_rx_axis_tready;
    assign in_hs     = cmac_rx_axis_tvalid && in_ready;

    assign accept = rx_engine_enable && (in_cnt >= 7'd42) &&
                    ((dst_mac == my_config_macAddr) || (dst_mac == 48'hFFFF_FFFF_FFFF)) &&
                    (etype == 16'h0800) && (ver_ihl == 8'h45) && (mf_frag == 14'd0) &&
                    (proto == 8'd17) && (dst_ip == my_config_ipAddr) &&
                    (dst_port == my_config_udpPort) && (udp_len > 16'd8);

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        emit       = 1'b0;
        beat_data  = {cmac_rx_axis_tdata[335:0], resid_reg};
        beat_keep  = '1;
        beat_last  = 1'b0;
        ev_ok      = 1'b0;
        ev_filt    = 1'b0;
        ev_miss    = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (cmac_rx_axis_tvalid) begin
                    if (accept) begin
                        state_next = LOOKUP;
                    end else if (cmac_rx_axis_tlast) begin
                        ev_filt = 1'b1;
                    end else begin
                        state_next = DROP;
                    end
                end
            end
            LOOKUP: begin
                if (s01_axis_fw_lookup_valid) begin
                    if (!s01_axis_fw_lookup_hit) begin
                        state_next = last_seen_reg ? IDLE : DROP;
                        ev_miss    = last_seen_reg;
                    end else if (rem_reg <= 16'd22 || last_seen_reg) begin
                        state_next = FLUSH;
                    end else begin
                        state_next = STREAM;
                    end
                end
            end
            STREAM: begin
                in_ready = out_free;
                if (cmac_rx_axis_tvalid && out_free) begin
                    emit = 1'b1;
                    if (rem_reg <= 16'd64) begin
                        beat_keep  = keep_mask(rem_reg[6:0]);
                        beat_last  = 1'b1;
                        state_next = cmac_rx_axis_tlast ? IDLE : DRAIN;
                        ev_ok      = cmac_rx_axis_tlast;
                    end else if (cmac_rx_axis_tlast) begin
                        // 22 held + in_cnt new bytes overflow one beat exactly when in_cnt > 42.
                        if (in_cnt > 7'd42) begin
                            state_next = FLUSH;
                        end else begin
                            beat_keep  = keep_mask(7'd22 + in_cnt);
                            beat_last  = 1'b1;
                            state_next = IDLE;
                            ev_ok      = 1'b1;
                        end
                    end
                end
            end
            FLUSH: begin
                beat_data = {336'd0, resid_reg};
                beat_keep = keep_mask(flush_cnt);
                beat_last = 1'b1;
                if (out_free) begin
                    emit       = (flush_cnt != 7'd0);
                    state_next = last_seen_reg ? IDLE : DRAIN;
                    ev_ok      = last_seen_reg;
                end
            end
            DRAIN: begin
                in_ready = 1'b1;
                if (cmac_rx_axis_tvalid && cmac_rx_axis_tlast) begin
                    state_next = IDLE;
                    ev_ok      = 1'b1;
                end
            end
            DROP: begin
                in_ready = 1'b1;
                if (cmac_rx_axis_tvalid && cmac_rx_axis_tlast) begin
                    state_next = IDLE;
                    ev_miss    = drop_miss_reg;
                    ev_filt    = !drop_miss_reg;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge rx_axis_aclk) begin
        if (rx_axis_areset) begin
            state_reg        <= IDLE;
            resid_reg        <= '0;
            rem_reg          <= '0;
            held_reg         <= '0;
            last_seen_reg    <= 1'b0;
            drop_miss_reg    <= 1'b0;
            conn_id_reg      <= '0;
            lookup_valid_reg <= 1'b0;
            lookup_mac_reg   <= '0;
            lookup_ip_reg    <= '0;
            lookup_port_reg  <= '0;
            out_data_reg     <= '0;
            out_keep_reg     <= '0;
            out_valid_reg    <= 1'b0;
            out_last_reg     <= 1'b0;
            out_user_reg     <= '0;
        end else begin
            state_reg        <= state_next;
            lookup_valid_reg <= 1'b0;
            if (state_reg == IDLE && in_hs) begin
                drop_miss_reg <= 1'b0;
                if (accept) begin
                    resid_reg        <= cmac_rx_axis_tdata[511:336];
                    rem_reg          <= udp_len - 16'd8;
                    held_reg         <= 5'(in_cnt - 7'd42);
                    last_seen_reg    <= cmac_rx_axis_tlast;
                    lookup_valid_reg <= 1'b1;
                    lookup_mac_reg   <= src_mac;
                    lookup_ip_reg    <= src_ip;
                    lookup_port_reg  <= src_port;
                end
            end
            if (state_reg == LOOKUP && s01_axis_fw_lookup_valid) begin
                drop_miss_reg <= 1'b1;
                conn_id_reg   <= s01_axis_fw_lookup_connectionId;
            end
            if (state_reg == STREAM && in_hs) begin
                resid_reg     <= cmac_rx_axis_tdata[511:336];
                rem_reg       <= rem_reg - 16'd64;
                held_reg      <= (in_cnt > 7'd42) ? 5'(in_cnt - 7'd42) : 5'd0;
                last_seen_reg <= cmac_rx_axis_tlast;
            end
            if (emit) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= beat_data;
                out_keep_reg  <= beat_keep;
                out_last_reg  <= beat_last;
                out_user_reg  <= conn_id_reg;
            end else if (udp_rx_axis_tready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign cmac_rx_axis_tready        = in_ready;
    assign udp_rx_axis_tdata          = out_data_reg;
    assign udp_rx_axis_tkeep          = out_keep_reg;
    assign udp_rx_axis_tvalid         = out_valid_reg;
    assign udp_rx_axis_tlast          = out_last_reg;
    assign udp_rx_axis_tuser          = out_user_reg;
    assign m01_axis_fw_lookup_valid   = lookup_valid_reg;
    assign m01_axis_fw_lookup_macAddr = lookup_mac_reg;
    assign m01_axis_fw_lookup_ipAddr  = lookup_ip_reg;
    assign m01_axis_fw_lookup_udpPort = lookup_port_reg;
    assign s01_axis_fw_lookup_ready   = 1'b1;

    logic unused_ok;
    assign unused_ok = m01_axis_fw_lookup_ready;

`ifdef ETH_RX_STATS_EN
    localparam logic [STAT_WIDTH-1:0] STAT_ONE = 1;
    logic [STAT_WIDTH-1:0] ok_cnt_reg, filt_cnt_reg, miss_cnt_reg;

    always_ff @(posedge rx_axis_aclk) begin
        if (rx_axis_areset) begin
            ok_cnt_reg   <= '0;
            filt_cnt_reg <= '0;
            miss_cnt_reg <= '0;
        end else begin
            if (ev_ok && !(&ok_cnt_reg))     ok_cnt_reg   <= ok_cnt_reg + STAT_ONE;
            if (ev_filt && !(&filt_cnt_reg)) filt_cnt_reg <= filt_cnt_reg + STAT_ONE;
            if (ev_miss && !(&miss_cnt_reg)) miss_cnt_reg <= miss_cnt_reg + STAT_ONE;
        end
    end

    assign stat_rx_ok       = ok_cnt_reg;
    assign stat_rx_filtered = filt_cnt_reg;
    assign stat_rx_miss     = miss_cnt_reg;
`else
    localparam int unused_stat_width = STAT_WIDTH;
    logic unused_events;
    assign unused_events = &{1'b0, ev_ok, ev_filt, ev_miss};
`endif

endmodule

// File: tb/tb_ethernet_rx.sv
// Bench for ethernet_rx: directed scenarios plus randomized frames checked against a payload-level model.
module tb_ethernet_rx;

    logic         clk = 1'b0;
    logic         srst;
    logic         enable;
    logic [47:0]  my_mac;
    logic [31:0]  my_ip;
    logic [15:0]  my_port;
    logic [511:0] tdata;
    logic [63:0]  tkeep;
    logic         tvalid, tlast, tready;
    logic [511:0] o_data;
    logic [63:0]  o_keep;
    logic         o_valid, o_last;
    logic [17:0]  o_user;
    logic         udp_tready = 1'b1;
    logic         m01_valid;
    logic [47:0]  m01_mac;
    logic [31:0]  m01_ip;
    logic [15:0]  m01_port;
    logic         s01_valid = 1'b0, s01_hit = 1'b0;
    logic [17:0]  s01_id = '0;
    logic         s01_ready;
`ifdef ETH_RX_STATS_EN
    logic [31:0]  st_ok, st_filt, st_miss;
`endif

    always #5 clk = ~clk;

    ethernet_rx dut (
        .rx_axis_aclk(clk), .rx_axis_areset(srst), .rx_engine_enable(enable),
        .my_config_macAddr(my_mac), .my_config_ipAddr(my_ip), .my_config_udpPort(my_port),
        .cmac_rx_axis_tdata(tdata), .cmac_rx_axis_tkeep(tkeep), .cmac_rx_axis_tvalid(tvalid),
        .cmac_rx_axis_tlast(tlast), .cmac_rx_axis_tready(tready),
        .udp_rx_axis_tdata(o_data), .udp_rx_axis_tkeep(o_keep), .udp_rx_axis_tvalid(o_valid),
        .udp_rx_axis_tlast(o_last), .udp_rx_axis_tuser(o_user), .udp_rx_axis_tready(udp_tready),
        .m01_axis_fw_lookup_valid(m01_valid), .m01_axis_fw_lookup_macAddr(m01_mac),
        .m01_axis_fw_lookup_ipAddr(m01_ip), .m01_axis_fw_lookup_udpPort(m01_port),
        .m01_axis_fw_lookup_ready(1'b1),
        .s01_axis_fw_lookup_valid(s01_valid), .s01_axis_fw_lookup_hit(s01_hit),
        .s01_axis_fw_lookup_connectionId(s01_id), .s01_axis_fw_lookup_ready(s01_ready)
`ifdef ETH_RX_STATS_EN
        , .stat_rx_ok(st_ok), .stat_rx_filtered(st_filt), .stat_rx_miss(st_miss)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    // Frame under construction / being sent, and the lookup answer for it.
    logic [7:0]  frm [0:383];
    int          frm_len;
    logic [47:0] src_mac;
    logic [31:0] src_ip;
    logic [15:0] src_port;
    logic        tb_hit;
    logic [17:0] tb_id;
    int          rdy_mode = 0;

    // Collected output, one entry per delivered packet.
    logic [7:0]  rx_bytes [$];
    int          rx_len [$];
    int          rx_beats [$];
    logic [17:0] rx_user [$];
    logic [63:0] rx_lastkeep [$];
    int          cur_len = 0, cur_beats = 0;
    logic [17:0] cur_user;
    int          stall_err = 0, keep_err = 0, user_err = 0;
    logic        prev_stall = 1'b0;
    logic [511:0] h_data;
    logic [63:0]  h_keep;
    logic         h_last;
    logic [17:0]  h_user;
    int          n_lookups = 0;
    logic [47:0] lk_mac;
    logic [31:0] lk_ip;
    logic [15:0] lk_port;
    logic [63:0] got_lastkeep;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    always begin
        @(negedge clk);
        s01_valid = 1'b0;
        if (m01_valid) begin
            s01_valid = 1'b1;
            s01_hit   = tb_hit;
            s01_id    = tb_id;
            n_lookups++;
            lk_mac  = m01_mac;
            lk_ip   = m01_ip;
            lk_port = m01_port;
        end
    end

    always begin
        int n;
        @(negedge clk);
        case (rdy_mode)
            0: udp_tready = 1'b1;
            1: udp_tready = ~udp_tready;
            2: udp_tready = 1'($urandom_range(0, 1));
            default: udp_tready = 1'b0;
        endcase
        #4;
        if (srst) begin
            prev_stall = 1'b0;
            cur_len = 0;
            cur_beats = 0;
        end else begin
            if (prev_stall && !(o_valid && o_data == h_data && o_keep == h_keep &&
                                o_last == h_last && o_user == h_user))
                stall_err++;
            if (o_valid && udp_tready) begin
                n = 0;
                for (int i = 0; i < 64; i++) if (o_keep[i]) n++;
                if (n == 0 || o_keep != ((n == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << n) - 64'd1)))
                    keep_err++;
                for (int i = 0; i < 64; i++) if (o_keep[i]) rx_bytes.push_back(o_data[8*i +: 8]);
                cur_len += n;
                cur_beats++;
                if (cur_beats == 1) cur_user = o_user;
                else if (o_user != cur_user) user_err++;
                if (o_last) begin
                    rx_len.push_back(cur_len);
                    rx_beats.push_back(cur_beats);
                    rx_user.push_back(cur_user);
                    rx_lastkeep.push_back(o_keep);
                    cur_len = 0;
                    cur_beats = 0;
                end
            end
            prev_stall = o_valid && !udp_tready;
            h_data = o_data; h_keep = o_keep; h_last = o_last; h_user = o_user;
        end
    end

    // Well-formed frame for the local endpoint carrying L random payload bytes.
    task automatic build(input int L, input logic [15:0] ulen);
        frm_len  = (42 + L < 60) ? 60 : 42 + L;
        src_mac  = {16'($urandom), 32'($urandom)};
        src_ip   = $urandom;
        src_port = 16'($urandom);
        for (int i = 0; i < frm_len; i++) frm[i] = 8'($urandom);
        for (int k = 0; k < 6; k++) begin
            frm[k]     = my_mac[47-8*k -: 8];
            frm[6 + k] = src_mac[47-8*k -: 8];
        end
        frm[12] = 8'h08; frm[13] = 8'h00; frm[14] = 8'h45;
        frm[20] = 8'h40; frm[21] = 8'h00; frm[23] = 8'd17;
        for (int k = 0; k < 4; k++) begin
            frm[26 + k] = src_ip[31-8*k -: 8];
            frm[30 + k] = my_ip[31-8*k -: 8];
        end
        for (int k = 0; k < 2; k++) begin
            frm[34 + k] = src_port[15-8*k -: 8];
            frm[36 + k] = my_port[15-8*k -: 8];
            frm[38 + k] = ulen[15-8*k -: 8];
        end
    endtask

    task automatic send(input int max_beats);
        int nb, b, t;
        logic hs;
        nb = (frm_len + 63) / 64;
        b = 0;
        t = 0;
        while (b < nb && b < max_beats && t < 1000) begin
            @(negedge clk);
            tvalid = 1'b1;
            tlast  = (b == nb - 1);
            for (int i = 0; i < 64; i++) begin
                tdata[8*i +: 8] = (b*64 + i < frm_len) ? frm[b*64 + i] : 8'h00;
                tkeep[i]        = (b*64 + i < frm_len);
            end
            #4;
            hs = tready;
            @(posedge clk);
            if (hs) b++;
            t++;
        end
        chk("send_timeout", 64'(t < 1000), 64'd1);
    endtask

    task automatic idle();
        @(negedge clk);
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic expect_pkt(input string tag, input int L, input logic [17:0] id);
        int t, len, bad;
        t = 0;
        while (rx_len.size() == 0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        chk({tag, "_delivered"}, 64'(rx_len.size() > 0), 64'd1);
        if (rx_len.size() > 0) begin
            len = rx_len.pop_front();
            chk({tag, "_len"}, 64'(len), 64'(L));
            chk({tag, "_beats"}, 64'(rx_beats.pop_front()), 64'((L + 63) / 64));
            chk({tag, "_tuser"}, 64'(rx_user.pop_front()), 64'(id));
            got_lastkeep = rx_lastkeep.pop_front();
            bad = 0;
            for (int k = 0; k < len; k++) begin
                if (rx_bytes.size() == 0 || k >= L) bad++;
                else if (rx_bytes.pop_front() != frm[42 + k]) bad++;
            end
            chk({tag, "_data_bad_bytes"}, 64'(bad), 64'd0);
        end
    endtask

    task automatic expect_drop(input string tag);
        repeat (20) @(posedge clk);
        chk({tag, "_no_output"}, 64'(rx_len.size() + rx_bytes.size()), 64'd0);
    endtask

    initial begin
        int lk0, kind, L;
        logic good;
        srst = 1'b1; enable = 1'b1; tvalid = 1'b0; tlast = 1'b0; tdata = '0; tkeep = '0;
        tb_hit = 1'b1; tb_id = '0;
        my_mac  = {16'($urandom), 32'($urandom)};
        my_ip   = $urandom;
        my_port = 16'($urandom_range(1024, 60000));
        repeat (3) @(negedge clk);
        #4;
        chk("rst_tvalid", 64'(o_valid), 64'd0);
        chk("rst_tkeep", o_keep, 64'd0);
        chk("rst_lookup_valid", 64'(m01_valid), 64'd0);
        chk("rst_s01_ready", 64'(s01_ready), 64'd1);
        @(negedge clk);
        srst = 1'b0;
        #4;
        chk("idle_tready", 64'(tready), 64'd1);

        // Single 64-byte frame, L = 22.
        build(22, 16'd30);
        tb_hit = 1'b1; tb_id = 18'h155;
        lk0 = n_lookups;
        send(99); idle();
        expect_pkt("t1", 22, 18'h155);
        chk("t1_lastkeep", got_lastkeep, 64'h3F_FFFF);
        chk("t1_lookups", 64'(n_lookups - lk0), 64'd1);
        chk("t1_lk_mac", lk_mac, src_mac);
        chk("t1_lk_ip", 64'(lk_ip), 64'(src_ip));
        chk("t1_lk_port", 64'(lk_port), 64'(src_port));

        // Three-beat frame with a toggling sink.
        rdy_mode = 1;
        build(150, 16'd158);
        tb_id = 18'h2_A5A5;
        send(99); idle();
        expect_pkt("t2", 150, 18'h2_A5A5);
        chk("t2_lastkeep", got_lastkeep, 64'h3F_FFFF);
        rdy_mode = 0;

        // Wrong port, then a matching frame back to back.
        lk0 = n_lookups;
        build(40, 16'd48);
        frm[37] = frm[37] + 8'd1;
        if (frm[37] == 8'd0) frm[36] = frm[36] + 8'd1;
        send(99);
        build(30, 16'd38);
        tb_id = 18'h0_0777;
        send(99); idle();
        expect_pkt("t3", 30, 18'h0_0777);
        chk("t3_lookups", 64'(n_lookups - lk0), 64'd1);

        // Lookup miss on a two-beat frame.
        build(80, 16'd88);
        tb_hit = 1'b0;
        send(99); idle();
        expect_drop("t4");
        chk("t4_tready_idle", 64'(tready), 64'd1);
`ifdef ETH_RX_STATS_EN
        chk("t4_stat_miss", 64'(st_miss), 64'd1);
`endif
        tb_hit = 1'b1;

        // Short frame with padding, L = 2.
        build(2, 16'd10);
        tb_id = 18'h3_0001;
        send(99); idle();
        expect_pkt("t5", 2, 18'h3_0001);
        chk("t5_lastkeep", got_lastkeep, 64'h3);

        // Reset while an output beat is stalled in STREAM.
        rdy_mode = 3;
        build(150, 16'd158);
        send(2); idle();
        #4;
        chk("t6_stalled_valid", 64'(o_valid), 64'd1);
        @(negedge clk);
        srst = 1'b1;
        @(negedge clk);
        srst = 1'b0;
        #4;
        chk("t6_valid_after_rst", 64'(o_valid), 64'd0);
        rdy_mode = 0;
        build(100, 16'd108);
        tb_id = 18'h1_2345;
        send(99); idle();
        expect_pkt("t6", 100, 18'h1_2345);

        // Randomized frames: accept/filter variants, hit/miss and sink patterns.
        for (int n = 0; n < 24; n++) begin
            kind = $urandom_range(0, 15);
            L    = $urandom_range(1, 260);
            build(L, 16'(L + 8));
            good = (kind <= 1) || (kind >= 12);
            case (kind)
                1:  for (int k = 0; k < 6; k++) frm[k] = 8'hFF;
                2:  frm[0] = frm[0] ^ 8'h01;
                3:  frm[12] = 8'h86;
                4:  frm[14] = 8'h46;
                5:  frm[20] = 8'h20;
                6:  frm[21] = 8'h01;
                7:  frm[23] = 8'd6;
                8:  frm[33] = frm[33] ^ 8'h01;
                9:  frm[37] = frm[37] ^ 8'h01;
                10: begin frm[38] = 8'h00; frm[39] = 8'd8; end
                11: enable = 1'b0;
                default: ;
            endcase
            tb_hit   = ($urandom_range(0, 3) != 0);
            tb_id    = 18'($urandom);
            rdy_mode = $urandom_range(0, 2);
            lk0 = n_lookups;
            send(99); idle();
            if (good && tb_hit) expect_pkt("rnd", L, tb_id);
            else expect_drop("rnd");
            chk("rnd_lookups", 64'(n_lookups - lk0), 64'(good));
            enable = 1'b1;
        end
        rdy_mode = 0;
        repeat (10) @(posedge clk);

        chk("stall_stability_errors", 64'(stall_err), 64'd0);
        chk("tkeep_shape_errors", 64'(keep_err), 64'd0);
        chk("tuser_change_errors", 64'(user_err), 64'd0);
        chk("leftover_packets", 64'(rx_len.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
